// File: rtl/modsub256_seq_ctrl_pkg.sv
// Shared ECC limb-arithmetic definitions: operand geometry, sequencer states
// and the limb-index type.
package ecc_arith_pkg;
  localparam int unsigned W       = 64;
  localparam int unsigned N_LIMBS = 4;
  localparam int unsigned OP_W    = W * N_LIMBS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [$clog2(N_LIMBS)-1:0] limb_idx_t;
endpackage

// File: rtl/modsub256_seq_ctrl_if.sv
// Start/done handshake and operand/result bus between the point-arithmetic
// scheduler (master) and the modular subtraction sequencer (slave).
interface modsub256_seq_ctrl_if
  import ecc_arith_pkg::*;
#(
  parameter int unsigned OP_W_P = OP_W
);
  logic              i_start;
  logic [OP_W_P-1:0] i_a;
  logic [OP_W_P-1:0] i_b;
  logic [OP_W_P-1:0] i_p;
  logic              o_busy;
  logic              o_done;
  logic [OP_W_P-1:0] o_result;

  modport master (output i_start, i_a, i_b, i_p, input o_busy, o_done, o_result);
  modport slave  (input i_start, i_a, i_b, i_p, output o_busy, o_done, o_result);
endinterface

// File: rtl/modsub256_seq_ctrl_limb_sub.sv
// Single-limb subtractor with borrow in/out: {bout, d} = x - y - bin.
module limb_sub_w #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_bin,
  output logic [W-1:0] o_d,
  output logic         o_bout
);
  logic [W:0] w_diff;

  assign w_diff = {1'b0, i_x} - {1'b0, i_y} - {{W{1'b0}}, i_bin};
  assign o_d    = w_diff[W-1:0];
  assign o_bout = w_diff[W];
endmodule

// File: rtl/modsub256_seq_ctrl.sv
// Limb-serial (a - b) mod p: a SUB pass, then an optional FIX pass computing
// r - (~(p & neg)) - 1, i.e. r + p when the first pass underflowed.
module modsub256_seq_ctrl
  import ecc_arith_pkg::*;
#(
  parameter int unsigned W          = ecc_arith_pkg::W,
  parameter int unsigned N_LIMBS    = ecc_arith_pkg::N_LIMBS,
  parameter bit          CONST_TIME = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  modsub256_seq_ctrl_if.slave  bus
);
  localparam int unsigned OPW   = W * N_LIMBS;
  localparam int unsigned IDX_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_LIMBS - 1);

  state_t           r_state;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [OPW-1:0]   r_p;
  logic [OPW-1:0]   r_res;
  logic [IDX_W-1:0] r_idx;
  logic             r_borrow;
  logic             r_neg;

  logic [W-1:0]     w_x;
  logic [W-1:0]     w_y;
  logic [W-1:0]     w_d;
  logic             w_bout;

  // One shared subtractor; FIX subtracts ~(p & neg) from the partial result.
  always_comb begin
    w_x = r_a[r_idx*W +: W];
    w_y = r_b[r_idx*W +: W];
    if (r_state == FIX) begin
      w_x = r_res[r_idx*W +: W];
      w_y = ~(r_p[r_idx*W +: W] & {W{r_neg}});
    end
  end

  limb_sub_w #(.W(W)) u_limb_sub (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_bin (r_borrow),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_a      <= bus.i_a;
            r_b      <= bus.i_b;
            r_p      <= bus.i_p;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_state  <= SUB;
          end
        end
        SUB: begin
          r_res[r_idx*W +: W] <= w_d;
          r_borrow            <= w_bout;
          r_idx               <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_neg <= w_bout;
            r_idx <= '0;
            if (w_bout || CONST_TIME) begin
              r_borrow <= 1'b1;
              r_state  <= FIX;
            end else begin
              r_state  <= DONE;
            end
          end
        end
        FIX: begin
          r_res[r_idx*W +: W] <= w_d;
          r_borrow            <= w_bout;
          r_idx               <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy   = (r_state != IDLE);
  assign bus.o_done   = (r_state == DONE);
  assign bus.o_result = r_res;
endmodule

// File: tb/tb_modsub256_seq_ctrl.sv
// Bench for modsub256_seq_ctrl: directed vectors, handshake/reset sequences
// and random operands against a plain-arithmetic model, for both CONST_TIME.
module tb_modsub256_seq_ctrl;
  import ecc_arith_pkg::*;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  modsub256_seq_ctrl_if if0 ();
  modsub256_seq_ctrl_if if1 ();

  modsub256_seq_ctrl #(.W(64), .N_LIMBS(4), .CONST_TIME(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  modsub256_seq_ctrl #(.W(64), .N_LIMBS(4), .CONST_TIME(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic [255:0] res;
    int           lat;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit ct, input logic st, input logic [255:0] a,
                       input logic [255:0] b, input logic [255:0] p);
    if (ct) begin
      if1.i_start = st; if1.i_a = a; if1.i_b = b; if1.i_p = p;
    end else begin
      if0.i_start = st; if0.i_a = a; if0.i_b = b; if0.i_p = p;
    end
  endtask

  function automatic logic get_busy(input bit ct);
    return ct ? if1.o_busy : if0.o_busy;
  endfunction
  function automatic logic get_done(input bit ct);
    return ct ? if1.o_done : if0.o_done;
  endfunction
  function automatic logic [255:0] get_res(input bit ct);
    return ct ? if1.o_result : if0.o_result;
  endfunction

  function automatic logic [255:0] model_res(input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] p);
    logic [256:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, p} - {1'b0, b};
    return t[255:0];
  endfunction

  function automatic int model_lat(input bit ct, input logic [255:0] a, input logic [255:0] b);
    return (ct || a < b) ? 9 : 5;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Start already driven; waits (bounded) for done, scrambling inputs after sampling.
  task automatic wait_op(input bit ct, output logic [255:0] res, output int lat, output int bcnt);
    res = '0; lat = 0; bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(ct, 1'b0, rand256(), rand256(), rand256());
      if (get_busy(ct)) bcnt++;
      if (get_done(ct)) begin
        lat = c;
        res = get_res(ct);
        break;
      end
    end
  endtask

  task automatic check_op(input string nm, input bit ct, input logic [255:0] a,
                          input logic [255:0] b, input logic [255:0] p,
                          input logic [255:0] exp_res, input int exp_lat);
    logic [255:0] res;
    int lat, bcnt;
    drive(ct, 1'b1, a, b, p);
    wait_op(ct, res, lat, bcnt);
    chk({nm, " latency"}, 256'(lat), 256'(exp_lat));
    chk({nm, " result"}, res, exp_res);
    chk({nm, " busy cycles"}, 256'(bcnt), 256'(exp_lat));
    @(posedge clk); #1;
    chk({nm, " done pulse width"}, 256'(get_done(ct)), 256'(0));
    chk({nm, " busy after done"}, 256'(get_busy(ct)), 256'(0));
    chk({nm, " result held"}, get_res(ct), exp_res);
  endtask

  initial begin
    logic [255:0] res, a, b, p;
    int lat, bcnt;

    tbl[0] = '{a: 256'd10, b: 256'd3, p: P, res: 256'd7, lat: 5};
    tbl[1] = '{a: 256'd3, b: 256'd10, p: P, res: P - 256'd7, lat: 9};
    tbl[2] = '{a: 256'd1 << 64, b: 256'd1, p: P,
               res: 256'h0000000000000000_0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF,
               lat: 5};
    tbl[3] = '{a: P - 256'd1, b: P - 256'd1, p: P, res: 256'd0, lat: 5};

    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    for (int ct = 0; ct < 2; ct++) begin
      chk("reset busy", 256'(get_busy(ct[0])), 256'(0));
      chk("reset done", 256'(get_done(ct[0])), 256'(0));
      chk("reset result", get_res(ct[0]), 256'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int ct = 0; ct < 2; ct++)
      for (int i = 0; i < 4; i++)
        check_op($sformatf("vec%0d ct%0d", i, ct), ct[0], tbl[i].a, tbl[i].b, tbl[i].p,
                 tbl[i].res, ct ? 9 : tbl[i].lat);

    // Starts while busy and in the DONE cycle are ignored; the next cycle accepts.
    drive(1'b0, 1'b1, 256'd10, 256'd3, P);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      drive(1'b0, (c == 2), 256'd99, 256'd1, P);
      if (if0.o_done) begin
        lat = c;
        break;
      end
    end
    chk("hs first latency", 256'(lat), 256'(5));
    chk("hs first result", if0.o_result, 256'd7);
    drive(1'b0, 1'b1, 256'd50, 256'd7, P);
    @(posedge clk); #1;
    chk("hs done-cycle start busy", 256'(if0.o_busy), 256'(0));
    chk("hs done-cycle start result", if0.o_result, 256'd7);
    drive(1'b0, 1'b1, 256'd3, 256'd10, P);
    wait_op(1'b0, res, lat, bcnt);
    chk("hs back-to-back latency", 256'(lat), 256'(9));
    chk("hs back-to-back result", res, P - 256'd7);
    @(posedge clk); #1;

    // Reset during the second FIX cycle aborts the operation.
    drive(1'b0, 1'b1, 256'd3, 256'd10, P);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      if (if0.o_done) chk("rst early done", 256'(1), 256'(0));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst abort busy", 256'(if0.o_busy), 256'(0));
    chk("rst abort done", 256'(if0.o_done), 256'(0));
    chk("rst abort result", if0.o_result, 256'd0);
    check_op("post-reset", 1'b0, 256'd10, 256'd3, P, 256'd7, 5);

    for (int n = 0; n < 24; n++) begin
      bit ct;
      ct = n[0];
      if (n % 3 == 0) p = P;
      else p = rand256() | {1'b1, 255'd1};
      a = rand256() % p;
      b = (n % 5 == 0) ? a : rand256() % p;
      check_op($sformatf("rand%0d ct%0d", n, ct), ct, a, b, p,
               model_res(a, b, p), model_lat(ct, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
